// File: rtl/univ_shift_reg_if.sv
// Signal bundle for univ_shift_reg: mode/data/serial inputs and register-side outputs.
// The parity port exists only when USR_PARITY_EN is defined.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic [2:0]       mode;
  logic [WIDTH-1:0] D;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] Q;
  logic             sout_l;
  logic             sout_r;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             done;
`ifdef USR_PARITY_EN
  logic             parity;

  modport master (
    output mode, D, sin_l, sin_r,
    input  Q, sout_l, sout_r, cnt, full, done, parity
  );
  modport slave (
    input  mode, D, sin_l, sin_r,
    output Q, sout_l, sout_r, cnt, full, done, parity
  );
`else
  modport master (
    output mode, D, sin_l, sin_r,
    input  Q, sout_l, sout_r, cnt, full, done
  );
  modport slave (
    input  mode, D, sin_l, sin_r,
    output Q, sout_l, sout_r, cnt, full, done
  );
`endif
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift/rotate register with saturating shift counter, full flag and done pulse.
// Optional registered parity output when USR_PARITY_EN is defined.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic            clk,
  input  logic            clear,
  univ_shift_reg_if.slave bus
);

  if (WIDTH < 2 || (1 << CNT_W) <= WIDTH) begin : g_param_check
    $error("univ_shift_reg: need WIDTH >= 2 and 2**CNT_W > WIDTH");
  end

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_ASR  = 3'b110,
    M_SCLR = 3'b111
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(WIDTH - 1);

  mode_e            mode;
  logic [WIDTH-1:0] q_r, q_next;
  logic [CNT_W-1:0] cnt_r, cnt_next;
  logic             full_r, done_r;
  logic             shift_op;

  assign mode = mode_e'(bus.mode);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    q_next   = q_r;
    shift_op = 1'b0;
    case (mode)
      M_HOLD: q_next = q_r;
      M_LOAD: q_next = bus.D;
      M_SHL: begin
        q_next   = {q_r[WIDTH-2:0], bus.sin_l};
        shift_op = 1'b1;
      end
      M_SHR: begin
        q_next   = {bus.sin_r, q_r[WIDTH-1:1]};
        shift_op = 1'b1;
      end
      M_ROL: begin
        q_next   = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        shift_op = 1'b1;
      end
      M_ROR: begin
        q_next   = {q_r[0], q_r[WIDTH-1:1]};
        shift_op = 1'b1;
      end
      M_ASR: begin
        q_next   = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
        shift_op = 1'b1;
      end
      M_SCLR: q_next = '0;
    endcase
  end

  // Counter clears on LOAD/SCLR, advances on shift-class modes and parks at WIDTH.
  always_comb begin
    cnt_next = cnt_r;
    if (mode == M_LOAD || mode == M_SCLR)
      cnt_next = '0;
    else if (shift_op && cnt_r != CNT_MAX)
      cnt_next = cnt_r + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q_r    <= '0;
      cnt_r  <= '0;
      full_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      q_r    <= q_next;
      cnt_r  <= cnt_next;
      full_r <= (cnt_next == CNT_MAX);
      done_r <= shift_op && (cnt_r == CNT_PRE);
    end
  end

`ifdef USR_PARITY_EN
  logic parity_r;

  // Taken from q_next so parity lands in the same cycle as the Q it describes.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) parity_r <= 1'b0;
    else       parity_r <= ^q_next;
  end

  assign bus.parity = parity_r;
`endif

  assign bus.Q      = q_r;
  assign bus.sout_l = q_r[WIDTH-1];
  assign bus.sout_r = q_r[0];
  assign bus.cnt    = cnt_r;
  assign bus.full   = full_r;
  assign bus.done   = done_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8): directed steps push hand-computed
// expectations, a monitor pops and compares them after each falling clock edge or clear.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                         ROL  = 3'b100, ROR  = 3'b101, ASR = 3'b110, SCLR = 3'b111;

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] q;
    logic [3:0] cnt;
    logic       full;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic clear = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  univ_shift_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .clear(clear),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int at_cyc, input string name, input logic [7:0] q,
                      input logic [3:0] cnt, input logic full, input logic done);
    exp_t e;
    e.cyc = at_cyc; e.name = name; e.q = q; e.cnt = cnt; e.full = full; e.done = done;
    sb.push_back(e);
  endtask

  // Drive one operation at posedge+1, expect its result after the next rising edge.
  task automatic step(input logic [2:0] m, input logic [7:0] d, input logic sl, input logic sr,
                      input string name, input logic [7:0] q, input logic [3:0] cnt,
                      input logic full, input logic done);
    bus.mode = m; bus.D = d; bus.sin_l = sl; bus.sin_r = sr;
    push(cyc + 1, name, q, cnt, full, done);
    @(posedge clk);
    #1;
  endtask

  always begin
    @(negedge clk or posedge clear);
    #1;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      check({mon_e.name, ".on_time"}, 32'(cyc), 32'(mon_e.cyc));
      check({mon_e.name, ".Q"},      32'(bus.Q),      32'(mon_e.q));
      check({mon_e.name, ".cnt"},    32'(bus.cnt),    32'(mon_e.cnt));
      check({mon_e.name, ".full"},   32'(bus.full),   32'(mon_e.full));
      check({mon_e.name, ".done"},   32'(bus.done),   32'(mon_e.done));
      check({mon_e.name, ".sout_l"}, 32'(bus.sout_l), 32'(mon_e.q[7]));
      check({mon_e.name, ".sout_r"}, 32'(bus.sout_r), 32'(mon_e.q[0]));
`ifdef USR_PARITY_EN
      check({mon_e.name, ".parity"}, 32'(bus.parity), 32'(^mon_e.q));
`endif
    end
  end

  initial begin
    bus.mode = HOLD; bus.D = 8'h00; bus.sin_l = 1'b0; bus.sin_r = 1'b0;
    clear = 1'b1;
    @(posedge clk);
    #1;
    push(cyc, "por", 8'h00, 4'd0, 1'b0, 1'b0);
    clear = 1'b0;

    // Async clear between edges, then held across an edge with LOAD on the inputs
    step(LOAD, 8'hA5, 1'b0, 1'b0, "load_a5", 8'hA5, 4'd0, 1'b0, 1'b0);
    bus.mode = LOAD; bus.D = 8'hFF;
    @(negedge clk);
    #2;
    push(cyc, "clr_async", 8'h00, 4'd0, 1'b0, 1'b0);
    clear = 1'b1;
    @(posedge clk);
    #1;
    push(cyc, "clr_held", 8'h00, 4'd0, 1'b0, 1'b0);
    clear = 1'b0;

    // Load and rotate
    step(LOAD, 8'h81, 1'b0, 1'b0, "load_81", 8'h81, 4'd0, 1'b0, 1'b0);
    step(ROL,  8'h00, 1'b0, 1'b0, "rol",     8'h03, 4'd1, 1'b0, 1'b0);
    step(ROR,  8'h00, 1'b0, 1'b0, "ror1",    8'h81, 4'd2, 1'b0, 1'b0);
    step(ROR,  8'h00, 1'b0, 1'b0, "ror2",    8'hC0, 4'd3, 1'b0, 1'b0);

    // Serial-to-parallel, saturation, HOLD and SCLR
    step(LOAD, 8'h00, 1'b0, 1'b0, "load_00", 8'h00, 4'd0, 1'b0, 1'b0);
    step(SHL, 8'h00, 1'b1, 1'b0, "shl1", 8'h01, 4'd1, 1'b0, 1'b0);
    step(SHL, 8'h00, 1'b0, 1'b0, "shl2", 8'h02, 4'd2, 1'b0, 1'b0);
    step(SHL, 8'h00, 1'b1, 1'b0, "shl3", 8'h05, 4'd3, 1'b0, 1'b0);
    step(SHL, 8'h00, 1'b1, 1'b0, "shl4", 8'h0B, 4'd4, 1'b0, 1'b0);
    step(SHL, 8'h00, 1'b0, 1'b0, "shl5", 8'h16, 4'd5, 1'b0, 1'b0);
    step(SHL, 8'h00, 1'b0, 1'b0, "shl6", 8'h2C, 4'd6, 1'b0, 1'b0);
    step(SHL, 8'h00, 1'b1, 1'b0, "shl7", 8'h59, 4'd7, 1'b0, 1'b0);
    step(SHL, 8'h00, 1'b0, 1'b0, "shl8", 8'hB2, 4'd8, 1'b1, 1'b1);
    step(SHL, 8'h00, 1'b1, 1'b0, "shl9", 8'h65, 4'd8, 1'b1, 1'b0);
    step(HOLD, 8'hFF, 1'b1, 1'b1, "hold1", 8'h65, 4'd8, 1'b1, 1'b0);
    step(HOLD, 8'hFF, 1'b1, 1'b1, "hold2", 8'h65, 4'd8, 1'b1, 1'b0);
    step(HOLD, 8'hFF, 1'b1, 1'b1, "hold3", 8'h65, 4'd8, 1'b1, 1'b0);
    step(SCLR, 8'hFF, 1'b1, 1'b1, "sclr",  8'h00, 4'd0, 1'b0, 1'b0);

    // LOAD then WIDTH arithmetic shifts fires done again; a saturated SHR does not
    step(LOAD, 8'h80, 1'b0, 1'b0, "load_80", 8'h80, 4'd0, 1'b0, 1'b0);
    step(ASR, 8'h00, 1'b0, 1'b0, "asr1", 8'hC0, 4'd1, 1'b0, 1'b0);
    step(ASR, 8'h00, 1'b0, 1'b0, "asr2", 8'hE0, 4'd2, 1'b0, 1'b0);
    step(ASR, 8'h00, 1'b0, 1'b0, "asr3", 8'hF0, 4'd3, 1'b0, 1'b0);
    step(ASR, 8'h00, 1'b0, 1'b0, "asr4", 8'hF8, 4'd4, 1'b0, 1'b0);
    step(ASR, 8'h00, 1'b0, 1'b0, "asr5", 8'hFC, 4'd5, 1'b0, 1'b0);
    step(ASR, 8'h00, 1'b0, 1'b0, "asr6", 8'hFE, 4'd6, 1'b0, 1'b0);
    step(ASR, 8'h00, 1'b0, 1'b0, "asr7", 8'hFF, 4'd7, 1'b0, 1'b0);
    step(ASR, 8'h00, 1'b0, 1'b0, "asr8", 8'hFF, 4'd8, 1'b1, 1'b1);
    step(SHR, 8'h00, 1'b0, 1'b0, "shr_sat", 8'h7F, 4'd8, 1'b1, 1'b0);

    // Arithmetic vs logical right shift
    step(LOAD, 8'h90, 1'b0, 1'b0, "load_90a", 8'h90, 4'd0, 1'b0, 1'b0);
    step(ASR,  8'h00, 1'b0, 1'b0, "asr_90",   8'hC8, 4'd1, 1'b0, 1'b0);
    step(LOAD, 8'h90, 1'b0, 1'b0, "load_90b", 8'h90, 4'd0, 1'b0, 1'b0);
    step(SHR,  8'h00, 1'b0, 1'b0, "shr_90",   8'h48, 4'd1, 1'b0, 1'b0);
    step(SHR,  8'h00, 1'b0, 1'b1, "shr_in1",  8'hA4, 4'd2, 1'b0, 1'b0);

    // Parity vectors (parity itself compared only in the parity build)
    step(LOAD, 8'h07, 1'b0, 1'b0, "load_07", 8'h07, 4'd0, 1'b0, 1'b0);
    step(SHL,  8'h00, 1'b1, 1'b0, "shl_0f",  8'h0F, 4'd1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
